tree_noc_link_pipe: RTL
=======================

# tree_noc_link_pipe

Parametrised, pipelined point-to-point link stage inserted between two tree-NoC router ports, or between a router port and an endpoint NI. It retimes flits, write strobes, per-VC credits and congestion info through `LINK_DEPTH` register stages in each direction, so long tree links can close timing. It also adds a start-gating FSM, per-VC in-flight accounting, a link-busy indication and sticky protocol-error flags, none of which plain wire-level tree interconnect provides.

## Interface
- `V`, default 4: virtual channels per port.
- `Fpay`, default 32: flit payload width. `Fw = 2+V+Fpay`, with `{hdr[1:0], vc_onehot[V-1:0], payload}` from MSB down.
- `LINK_DEPTH`, default 2: register stages per direction, legal range 0..8. A value of 0 means a pure combinational pass-through.
- `CONGw`, default 2: congestion field width.
- `CNTw`, default 4: width of each in-flight counter. Must satisfy `2^CNTw > LINK_DEPTH`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `start_i`  in  1  one-cycle pulse that enables the link.
- `flit_in`  in  Fw  flit from the upstream port.
- `flit_in_wr`  in  1  write strobe for `flit_in`.
- `flit_out`  out  Fw  flit to the downstream port.
- `flit_out_wr`  out  1  write strobe for `flit_out`.
- `credit_in`  in  V  per-VC credit pulses from downstream.
- `credit_out`  out  V  credits delivered upstream.
- `cong_in`  in  CONGw  congestion info from downstream.
- `cong_out`  out  CONGw  congestion info delivered upstream.
- `inflight`  out  V*CNTw  per-VC count of flits inside the flit pipeline.
- `link_busy`  out  1  high when any flit or credit stage is valid.
- `active`  out  1  FSM is in the ACTIVE state.
- `err`  out  2  sticky error flags. Bit 0: a write arrived while not ACTIVE. Bit 1: a write carried a VC field that is not one-hot.

## Operation
- FSM has two states: WAIT (the reset state) and ACTIVE.
  - WAIT→ACTIVE on `start_i`=1.
  - ACTIVE never leaves except on `reset`.
  - `active` is a registered copy of the state.
- In WAIT:
  - `flit_in_wr` is dropped and no stage is loaded. Set `err[0]`.
  - Credits and congestion still propagate, so the reset-time credit handshake is not lost.
- In ACTIVE:
  - Stage 0 captures `{flit_in_wr, flit_in}` each cycle. Stage k captures from stage k-1.
  - `flit_out`/`flit_out_wr` come from the last stage.
  - Data registers load only when the incoming valid is 1. When valid is 0, the data register holds its value; only the valid bit is cleared.
- Credit and congestion path:
  - Independent `LINK_DEPTH`-stage shift of `credit_in` and `cong_in`, running in every FSM state.
  - Credits are never merged or dropped: each credit bit emerges exactly `LINK_DEPTH` cycles later.
- Error check: a write with `vc_onehot` of popcount ≠ 1 is still forwarded unchanged and sets `err[1]`. Such a write increments no counter.
- In-flight counters, one per VC:
  - Increment when stage 0 loads a valid flit on that VC.
  - Decrement when the last stage presents a valid flit on that VC.
  - Simultaneous increment and decrement on the same VC leave the count unchanged.
  - Counts saturate at 0 and at `2^CNTw-1`; saturation never occurs for legal `CNTw`.
- `link_busy` = OR of all flit-stage and credit-stage valid bits.
- With `LINK_DEPTH`=0:
  - Outputs equal inputs combinationally, except that writes are gated by `active`.
  - `inflight` is all 0 and `link_busy` is 0.
  - FSM and err logic still operate.
- `err` bits clear only on `reset`.

## Timing
- Flit latency is exactly `LINK_DEPTH` cycles from `flit_in_wr` to `flit_out_wr`. Credit and congestion latency is also `LINK_DEPTH` cycles.
- Back-to-back writes every cycle are sustained with no bubbles.
- Reset (synchronous) forces, on the next edge:
  - state to WAIT and `active`=0;
  - all valid bits, data registers and `flit_out` to 0;
  - `flit_out_wr`=0, `credit_out`=0, `cong_out`=0;
  - `inflight`=0, `link_busy`=0, `err`=0.
- Reset mid-traffic discards in-flight flits and credits without emitting them; counters return to 0.
- `start_i` on cycle t: a write on cycle t is dropped and flags `err[0]`. A write on cycle t+1 is accepted.
- `start_i` while already ACTIVE has no effect.
- `inflight` and `link_busy` are updated on the same edge as the stage registers and are visible in the cycle after the event.

## Test plan
- **Reset and start.** `LINK_DEPTH`=2. Hold `reset` for 3 cycles, then pulse `start_i` at cycle 5, then write a head flit on VC1 at cycle 6. Expect all outputs 0 during reset, `active`=1 from cycle 6, and `flit_out_wr`=1 at cycle 8 with an identical flit.
- **Pre-start drop.** Write on VC0 while in WAIT. Expect no `flit_out_wr` ever, `err`=2'b01 and `inflight`=0.
- **Streaming.** `LINK_DEPTH`=3, V=4. Send 10 back-to-back flits cycling VC0..VC3. Expect 10 outputs in order, each delayed by exactly 3 cycles. Expect `inflight[VC0]` to peak at 1 and `link_busy` to fall 3 cycles after the last write.
- **Credits.** Pulse `credit_in`=4'b1010 and the next cycle 4'b0001, before `start_i`. Expect `credit_out` to show the same two patterns `LINK_DEPTH` cycles later.
- **Bad VC.** Write with `vc_onehot`=4'b0110. Expect the flit forwarded, `err[1]`=1 and all `inflight` unchanged.
- **Depth 0 and reset mid-flight.** With `LINK_DEPTH`=0, expect `flit_out` to equal `flit_in` in the same cycle once active. With `LINK_DEPTH`=4, assert `reset` while 3 flits are in flight. Expect no emission afterwards and `inflight`=0.

Source files
------------

// File: rtl/tree_noc_link_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : tree_noc_link_pipe_if
//  Description : Bundle of the flit, credit, congestion and status signals
//                crossing a tree-NoC link pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tree_noc_link_pipe_if #(
    parameter int V     = 4,
    parameter int Fpay  = 32,
    parameter int CONGw = 2,
    parameter int CNTw  = 4
);
    localparam int FW = 2 + V + Fpay;

    logic                 start_i;
    logic [FW-1:0]        flit_in;
    logic                 flit_in_wr;
    logic [FW-1:0]        flit_out;
    logic                 flit_out_wr;
    logic [V-1:0]         credit_in;
    logic [V-1:0]         credit_out;
    logic [CONGw-1:0]     cong_in;
    logic [CONGw-1:0]     cong_out;
    logic [V*CNTw-1:0]    inflight;
    logic                 link_busy;
    logic                 active;
    logic [1:0]           err;

    // Driver side: the environment feeding the link stage.
    modport master (
        output start_i, flit_in, flit_in_wr, credit_in, cong_in,
        input  flit_out, flit_out_wr, credit_out, cong_out,
               inflight, link_busy, active, err
    );

    // Link stage side.
    modport slave (
        input  start_i, flit_in, flit_in_wr, credit_in, cong_in,
        output flit_out, flit_out_wr, credit_out, cong_out,
               inflight, link_busy, active, err
    );
endinterface
`default_nettype wire

// File: rtl/tree_noc_link_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tree_noc_link_pipe
//  Description : Pipelined tree-NoC link stage. Retimes flits, credits and
//                congestion info through LINK_DEPTH registers per direction,
//                gates writes with a start FSM, tracks per-VC in-flight flits
//                and raises sticky protocol-error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tree_noc_link_pipe #(
    parameter int V          = 4,
    parameter int Fpay       = 32,
    parameter int LINK_DEPTH = 2,
    parameter int CONGw      = 2,
    parameter int CNTw       = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    tree_noc_link_pipe_if.slave lnk
);
    localparam int FW = 2 + V + Fpay;

    typedef enum logic [0:0] {
        S_WAIT   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_active;
    logic [1:0] r_err;
    logic       w_accept;
    logic       w_vc_ok;

    // True when exactly one bit of the VC field is set.
    function automatic logic f_onehot(input logic [V-1:0] i_vc);
        int n;
        n = 0;
        for (int b = 0; b < V; b++) begin
            n = n + int'(i_vc[b]);
        end
        return (n == 1);
    endfunction

    assign w_vc_ok  = f_onehot(lnk.flit_in[Fpay +: V]);
    // Writes are only taken while ACTIVE; a write in the start cycle is dropped.
    assign w_accept = lnk.flit_in_wr && (r_state == S_ACTIVE);

    // Start-gating FSM with registered active flag and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_WAIT;
            r_active <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (lnk.start_i) begin
                        r_state  <= S_ACTIVE;
                        r_active <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    r_active <= 1'b1;
                end
                default: begin
                    r_state  <= S_WAIT;
                    r_active <= 1'b0;
                end
            endcase
            if (lnk.flit_in_wr && (r_state != S_ACTIVE)) r_err[0] <= 1'b1;
            if (lnk.flit_in_wr && !w_vc_ok)              r_err[1] <= 1'b1;
        end
    end

    assign lnk.active = r_active;
    assign lnk.err    = r_err;

    generate
        if (LINK_DEPTH == 0) begin : g_bypass
            // Pure wire-through; only the write strobe is gated by the FSM.
            assign lnk.flit_out    = lnk.flit_in;
            assign lnk.flit_out_wr = w_accept;
            assign lnk.credit_out  = lnk.credit_in;
            assign lnk.cong_out    = lnk.cong_in;
            assign lnk.inflight    = '0;
            assign lnk.link_busy   = 1'b0;
        end else begin : g_pipe
            logic [LINK_DEPTH-1:0] r_vld;
            logic [FW-1:0]         r_dat [LINK_DEPTH];
            logic [V-1:0]          r_cr  [LINK_DEPTH];
            logic [CONGw-1:0]      r_cg  [LINK_DEPTH];
            logic [CNTw-1:0]       r_cnt [V];
            logic [FW-1:0]         w_out_dat;
            logic                  w_out_ok;
            logic [V-1:0]          w_inc;
            logic [V-1:0]          w_dec;
            logic                  w_cr_any;

            // Flit stages: valid bits always shift, data only loads on valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                    for (int k = 0; k < LINK_DEPTH; k++) begin
                        r_dat[k] <= '0;
                    end
                end else begin
                    r_vld[0] <= w_accept;
                    if (w_accept) r_dat[0] <= lnk.flit_in;
                    for (int k = 1; k < LINK_DEPTH; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        if (r_vld[k-1]) r_dat[k] <= r_dat[k-1];
                    end
                end
            end

            // Credit/congestion shift runs in every FSM state so reset-time
            // credit handshakes are not lost.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < LINK_DEPTH; k++) begin
                        r_cr[k] <= '0;
                        r_cg[k] <= '0;
                    end
                end else begin
                    r_cr[0] <= lnk.credit_in;
                    r_cg[0] <= lnk.cong_in;
                    for (int k = 1; k < LINK_DEPTH; k++) begin
                        r_cr[k] <= r_cr[k-1];
                        r_cg[k] <= r_cg[k-1];
                    end
                end
            end

            assign w_out_dat = r_dat[LINK_DEPTH-1];
            assign w_out_ok  = f_onehot(w_out_dat[Fpay +: V]);
            // Flits with an illegal VC field are forwarded but never counted.
            assign w_inc = (w_accept && w_vc_ok) ? lnk.flit_in[Fpay +: V] : '0;
            assign w_dec = (r_vld[LINK_DEPTH-1] && w_out_ok) ? w_out_dat[Fpay +: V] : '0;

            // Per-VC in-flight counters, saturating at both ends.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int v = 0; v < V; v++) begin
                        r_cnt[v] <= '0;
                    end
                end else begin
                    for (int v = 0; v < V; v++) begin
                        if (w_inc[v] && !w_dec[v] && (r_cnt[v] != {CNTw{1'b1}})) begin
                            r_cnt[v] <= r_cnt[v] + CNTw'(1);
                        end else if (w_dec[v] && !w_inc[v] && (r_cnt[v] != '0)) begin
                            r_cnt[v] <= r_cnt[v] - CNTw'(1);
                        end
                    end
                end
            end

            // Any credit bit still travelling keeps the link busy.
            always_comb begin
                w_cr_any = 1'b0;
                for (int k = 0; k < LINK_DEPTH; k++) begin
                    w_cr_any = w_cr_any | (|r_cr[k]);
                end
            end

            for (genvar v = 0; v < V; v++) begin : g_cnt
                assign lnk.inflight[v*CNTw +: CNTw] = r_cnt[v];
            end

            assign lnk.flit_out    = w_out_dat;
            assign lnk.flit_out_wr = r_vld[LINK_DEPTH-1];
            assign lnk.credit_out  = r_cr[LINK_DEPTH-1];
            assign lnk.cong_out    = r_cg[LINK_DEPTH-1];
            assign lnk.link_busy   = (|r_vld) | w_cr_any;
        end
    endgenerate

endmodule
`default_nettype wire
